fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream.sv | 79 +++++++
 tb/tb_fifo_rd_stream.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side FIFO adapter: pops FIFO words into a 2-entry head/skid buffer and
// presents them as a valid/ready stream framed into BEATS-long packets.
module fifo_rd_stream #(
  parameter int unsigned W     = 8,
  parameter int unsigned BEATS = 4
) (
  input  logic         rclk,
  input  logic         rrst_n,
  input  logic         rempty,
  input  logic [W-1:0] rdata,
  output logic         rinc,
  output logic         m_valid,
  output logic [W-1:0] m_data,
  output logic         m_last,
  input  logic         m_ready
);

  localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  logic [1:0]    cnt;
  logic [W-1:0]  head;
  logic [W-1:0]  skid;
  logic [BW-1:0] bcnt;
  logic          push;
  logic          pop;
  logic [2:0]    cnt_nxt;

  // Pop only while buffer space exists; m_ready is deliberately not involved.
  assign rinc    = rrst_n & ~rempty & (cnt != 2'd2);
  assign push    = rinc;
  assign pop     = m_valid & m_ready;
  assign cnt_nxt = 3'(cnt) + 3'(push) - 3'(pop);

  assign m_valid = (cnt != 2'd0);
  assign m_data  = head;
  assign m_last  = m_valid & (bcnt == LAST_BEAT);

  // Head always holds the oldest word; skid holds the second when cnt=2.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt  <= 2'd0;
      head <= '0;
      skid <= '0;
    end else begin
      cnt <= cnt_nxt[1:0];
      case (cnt)
        2'd0: begin
          if (push) head <= rdata;
        end
        2'd1: begin
          if (push && !pop)     skid <= rdata;
          else if (push && pop) head <= rdata;
        end
        2'd2: begin
          if (pop) head <= skid;
        end
        default: ;
      endcase
    end
  end

  // Beat position within the current packet, advanced per accepted word.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      bcnt <= '0;
    end else if (pop) begin
      bcnt <= (bcnt == LAST_BEAT) ? '0 : bcnt + BW'(1);
    end
  end

`ifndef SYNTHESIS
  a_cnt_range : assert property (@(posedge rclk) disable iff (!rrst_n) cnt_nxt <= 3'd2)
    else $error("fifo_rd_stream: occupancy leaves 0..2 (cnt=%0d next=%0d)", cnt, cnt_nxt);
  a_pop_empty : assert property (@(posedge rclk) disable iff (!rrst_n) !(pop && cnt == 2'd0))
    else $error("fifo_rd_stream: pop with empty buffer");
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: behavioural FIFO models, a negedge
// monitor/scoreboard, and hand-timed checks for reset, streaming and backpressure.
module tb_fifo_rd_stream;

  localparam int unsigned W = 8;

  logic         rclk = 1'b0;
  logic         rrst_n;
  logic         rempty, rinc, m_valid, m_last, m_ready;
  logic [W-1:0] rdata, m_data;
  logic         rempty_b, rinc_b, m_valid_b, m_last_b, m_ready_b;
  logic [W-1:0] rdata_b, m_data_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 rclk = ~rclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  fifo_rd_stream #(.W(W), .BEATS(4)) dut_a (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
  );

  fifo_rd_stream #(.W(W), .BEATS(1)) dut_b (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty_b), .rdata(rdata_b), .rinc(rinc_b),
    .m_valid(m_valid_b), .m_data(m_data_b), .m_last(m_last_b), .m_ready(m_ready_b)
  );

  // FIFO models: a word array with read/write pointers; reads advance on rinc.
  logic [W-1:0] mem_a [0:2047];
  logic [W-1:0] mem_b [0:15];
  int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;

  assign rempty   = (wr_a == rd_a);
  assign rdata    = mem_a[rd_a[10:0]];
  assign rempty_b = (wr_b == rd_b);
  assign rdata_b  = mem_b[rd_b[3:0]];

  always @(posedge rclk) begin
    if (rinc)   rd_a <= rd_a + 1;
    if (rinc_b) rd_b <= rd_b + 1;
  end

  task automatic push_a(input logic [W-1:0] d);
    mem_a[wr_a[10:0]] = d;
    wr_a++;
  endtask

  task automatic push_b(input logic [W-1:0] d);
    mem_b[wr_b[3:0]] = d;
    wr_b++;
  endtask

  // Scoreboard for the BEATS=4 instance; words dropped by reset are skipped.
  int acc_a = 0, idx_a = 0, beat_a = 0, rinc_n_a = 0;
  always @(negedge rclk) begin
    if (!rrst_n) begin
      check("rst_rinc",  32'(rinc),    32'(0));
      check("rst_valid", 32'(m_valid), 32'(0));
      check("rst_data",  32'(m_data),  32'(0));
      check("rst_last",  32'(m_last),  32'(0));
      idx_a  <= rd_a;
      beat_a <= 0;
    end else begin
      if (rempty) check("a_rinc_on_empty", 32'(rinc), 32'(0));
      if (rinc) rinc_n_a <= rinc_n_a + 1;
      if (m_valid && m_ready) begin
        check("a_data", 32'(m_data), 32'(mem_a[idx_a[10:0]]));
        check("a_last", 32'(m_last), 32'((beat_a % 4) == 3));
        idx_a  <= idx_a + 1;
        beat_a <= beat_a + 1;
        acc_a  <= acc_a + 1;
      end else if (m_valid) begin
        check("a_hold", 32'(m_data), 32'(mem_a[idx_a[10:0]]));
      end
    end
  end

  // Scoreboard for the BEATS=1 instance: every beat is a last beat.
  int acc_b = 0, idx_b = 0;
  always @(negedge rclk) begin
    if (!rrst_n) begin
      idx_b <= rd_b;
    end else begin
      if (rempty_b) check("b_rinc_on_empty", 32'(rinc_b), 32'(0));
      if (m_valid_b && m_ready_b) begin
        check("b_data", 32'(m_data_b), 32'(mem_b[idx_b[3:0]]));
        check("b_last", 32'(m_last_b), 32'(1));
        idx_b <= idx_b + 1;
        acc_b <= acc_b + 1;
      end
    end
  end

  task automatic do_reset();
    @(posedge rclk);
    #1 rrst_n = 1'b0;
    @(posedge rclk);
    #1 rrst_n = 1'b1;
  endtask

  int s_acc, s_rinc, sent, cyc;

  initial begin
    rrst_n    = 1'b0;
    m_ready   = 1'b0;
    m_ready_b = 1'b0;

    // Reset with two words already waiting in the FIFO.
    push_a(8'hA1);
    push_a(8'hA2);
    repeat (3) @(negedge rclk);
    check("rst_hold_rinc", 32'(rinc), 32'(0));
    @(posedge rclk);
    #1 rrst_n = 1'b1;
    #1;
    check("rel_rinc",  32'(rinc),    32'(1));
    check("rel_valid", 32'(m_valid), 32'(0));
    @(posedge rclk);
    #1;
    check("lat_valid", 32'(m_valid), 32'(1));
    check("lat_data",  32'(m_data),  32'(8'hA1));
    m_ready = 1'b1;
    repeat (3) @(posedge rclk);
    #1 check("p1_drained", 32'(m_valid), 32'(0));

    // Full-throughput streaming of 8 words, packets of 4.
    do_reset();
    s_acc  = acc_a;
    s_rinc = rinc_n_a;
    for (int i = 0; i < 8; i++) push_a(8'(8'h10 + i));
    repeat (9) @(posedge rclk);
    #1;
    check("str_count", 32'(acc_a - s_acc),     32'(8));
    check("str_rinc",  32'(rinc_n_a - s_rinc), 32'(8));
    check("str_empty", 32'(m_valid),           32'(0));
    repeat (3) @(posedge rclk);
    #1 check("str_rinc_idle", 32'(rinc_n_a - s_rinc), 32'(8));

    // Backpressure: only two words fetched while m_ready is low.
    do_reset();
    m_ready = 1'b0;
    s_acc   = acc_a;
    s_rinc  = rinc_n_a;
    for (int i = 0; i < 5; i++) push_a(8'(8'h30 + i));
    repeat (10) @(posedge rclk);
    #1;
    check("bp_rinc_n", 32'(rinc_n_a - s_rinc), 32'(2));
    check("bp_rinc",   32'(rinc),              32'(0));
    check("bp_valid",  32'(m_valid),           32'(1));
    check("bp_data",   32'(m_data),            32'(8'h30));
    m_ready = 1'b1;
    @(negedge rclk);
    check("bp_rinc_full", 32'(rinc), 32'(0));
    @(posedge rclk);
    #1 check("bp_rinc_back", 32'(rinc), 32'(1));
    repeat (8) @(posedge rclk);
    #1;
    check("bp_count",  32'(acc_a - s_acc),     32'(5));
    check("bp_rinc_t", 32'(rinc_n_a - s_rinc), 32'(5));
    check("bp_empty",  32'(m_valid),           32'(0));

    // Random backpressure with bursty refill over 1000 words.
    do_reset();
    s_acc = acc_a;
    sent  = 0;
    cyc   = 0;
    while ((acc_a - s_acc) < 1000 && cyc < 20000) begin
      @(posedge rclk);
      #1;
      cyc++;
      m_ready = 1'($urandom_range(0, 1));
      if (sent < 1000 && $urandom_range(0, 9) < 4) begin
        push_a(8'($urandom));
        sent++;
      end
    end
    check("rand_count", 32'(acc_a - s_acc), 32'(1000));

    // BEATS=1 instance: m_last on every beat.
    @(posedge rclk);
    #1;
    m_ready_b = 1'b1;
    push_b(8'h51);
    push_b(8'h52);
    push_b(8'h53);
    repeat (6) @(posedge rclk);
    #1 check("b_count", 32'(acc_b), 32'(3));

    // Reset mid-packet after two beats with both buffer entries full.
    m_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) push_a(8'(8'h60 + i));
    repeat (3) @(posedge rclk);
    #1;
    check("mp_full_valid", 32'(m_valid), 32'(1));
    check("mp_full_rinc",  32'(rinc),    32'(0));
    m_ready = 1'b1;
    repeat (2) @(posedge rclk);
    #1 m_ready = 1'b0;
    @(posedge rclk);
    #1;
    check("mp_pre_valid", 32'(m_valid), 32'(1));
    check("mp_pre_rinc",  32'(rinc),    32'(0));
    check("mp_pre_data",  32'(m_data),  32'(8'h62));
    check("mp_pre_last",  32'(m_last),  32'(0));
    #2 rrst_n = 1'b0;
    #1;
    check("mp_clr_valid", 32'(m_valid), 32'(0));
    check("mp_clr_data",  32'(m_data),  32'(0));
    check("mp_clr_last",  32'(m_last),  32'(0));
    check("mp_clr_rinc",  32'(rinc),    32'(0));
    @(posedge rclk);
    #1 rrst_n = 1'b1;
    m_ready = 1'b1;
    s_acc   = acc_a;
    repeat (12) @(posedge rclk);
    #1;
    check("mp_count", 32'(acc_a - s_acc), 32'(8));
    check("mp_empty", 32'(m_valid),       32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
